knight_cmd_if: RTL and testbench

Knight-side endpoint of the remote command link: deserializes the two-byte UART command stream sent by the remote controller into a 16-bit `cmd` with a `cmd_rdy` flag, and serializes the 8-bit response byte back over the same link. Sits between the `RX`/`TX` pins and the command processor: it consumes what the controller's `send_cmd`/`cmd` path produces and feeds its `resp_rdy`/`resp` path. Contains its own 8N1 receiver, transmitter and byte-assembly FSM.

---
 rtl/knight_cmd_if.sv | 178 +++++++++++++++++
 tb/tb_knight_cmd_if.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/knight_cmd_if.sv
// knight_cmd_if: knight-side endpoint of the remote command link.
// It receives 8N1 UART bytes on RX, pairs them (high byte first) into a
// 16-bit command with a ready flag, and sends 8-bit response bytes on TX.
// The receive and transmit paths are independent, so full-duplex traffic works.
module knight_cmd_if #(
    parameter int BAUD_DIV = 5208              // clocks per bit period, >= 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    // The counter must be able to hold a full bit period.
    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bits;
    logic [7:0]       rx_data;
    logic             byte_rdy;

    // Two-flop synchronizer for the asynchronous RX pin; resets to idle-high
    // so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    // Receive FSM: half-period delay to land mid start bit, then one sample
    // per bit period. Samples 1..8 are the data bits, shifted in LSB first.
    // The start and stop samples are counted but not kept, since neither is
    // checked. byte_rdy pulses on the cycle after the stop-bit sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_data  <= '0;
            byte_rdy <= 1'b0;
        end else begin
            byte_rdy <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_RECV;
                        rx_cnt   <= HALF_CNT;
                        rx_bits  <= '0;
                    end
                end
                RX_RECV: begin
                    if (rx_cnt == LAST_CNT) begin
                        rx_cnt  <= FULL_CNT;
                        rx_bits <= rx_bits + 4'd1;
                        if ((rx_bits >= 4'd1) && (rx_bits <= 4'd8)) begin
                            rx_data <= {rx_sync, rx_data[7:1]};
                        end
                        if (rx_bits == 4'd9) begin
                            rx_state <= RX_IDLE;
                            byte_rdy <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - LAST_CNT;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command assembly
    // ------------------------------------------------------------------
    asm_state_t asm_state;
    logic [7:0] high_byte;

    // Pairs received bytes into a command. A new first byte withdraws the
    // previous command's ready flag; a completing second byte sets it and
    // takes priority over a simultaneous clr_cmd_rdy so no command is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_state <= ASM_HIGH;
            high_byte <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else if (byte_rdy) begin
            case (asm_state)
                ASM_HIGH: begin
                    high_byte <= rx_data;
                    cmd_rdy   <= 1'b0;
                    asm_state <= ASM_LOW;
                end
                ASM_LOW: begin
                    cmd       <= {high_byte, rx_data};
                    cmd_rdy   <= 1'b1;
                    asm_state <= ASM_HIGH;
                end
                default: asm_state <= ASM_HIGH;
            endcase
        end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bits;
    logic [9:0]       tx_shift;

    // Transmit FSM: the frame {stop, data, start} is shifted out LSB first,
    // one bit per period, with 1s filling from the top. After ten periods
    // the register is all ones again, so its LSB doubles as the idle level.
    // trmt is only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
            tx_done  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift <= {1'b1, resp, 1'b0};
                        tx_cnt   <= FULL_CNT;
                        tx_bits  <= '0;
                        tx_done  <= 1'b0;
                        tx_state <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_cnt == LAST_CNT) begin
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_cnt   <= FULL_CNT;
                        tx_bits  <= tx_bits + 4'd1;
                        if (tx_bits == 4'd9) begin
                            tx_state <= TX_IDLE;
                            tx_done  <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - LAST_CNT;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign TX = tx_shift[0];

endmodule

// File: tb/tb_knight_cmd_if.sv
// Self-checking bench for knight_cmd_if at BAUD_DIV = 16.
// Directed and randomized UART traffic; expected command/flag values come
// from a command-level model, expected TX levels from the frame definition.
module tb_knight_cmd_if;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    // command-level model
    logic [15:0] exp_cmd;
    logic        exp_rdy;

    // rising edges of cmd_rdy
    int   rises = 0;
    logic prev_rdy = 1'b0;

    knight_cmd_if #(.BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) rises++;
        prev_rdy = cmd_rdy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Level of bit i (0..9) of an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // One RX frame, driven on negedges. If clr_late, clr_cmd_rdy is pulsed
    // so it is sampled on the same edge the assembly logic sees the byte.
    task automatic send_byte(input logic [7:0] b, input bit clr_late);
        for (int c = 0; c < 10 * BD; c++) begin
            RX = frame_bit(b, c / BD);
            clr_cmd_rdy = (clr_late && c == 9 * BD + BD / 2 + 3);
            @(negedge clk);
        end
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] c, input bit clr_late, input string tag);
        send_byte(c[15:8], 1'b0);
        exp_rdy = 1'b0;
        check({tag, "_hi_rdy"}, cmd_rdy, exp_rdy);
        check({tag, "_hi_cmd"}, cmd, exp_cmd);
        send_byte(c[7:0], clr_late);
        exp_cmd = c;
        exp_rdy = 1'b1;
        check({tag, "_lo_rdy"}, cmd_rdy, exp_rdy);
        check({tag, "_lo_cmd"}, cmd, exp_cmd);
    endtask

    task automatic clr_pulse(input string tag);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        check({tag, "_clr_rdy"}, cmd_rdy, exp_rdy);
        check({tag, "_clr_cmd"}, cmd, exp_cmd);
    endtask

    // Sends b and checks each bit mid-period plus tx_done timing. With
    // retrig, a second trmt (resp 0) is issued mid-frame and must be ignored.
    task automatic tx_frame(input logic [7:0] b, input bit retrig, input string tag);
        resp = b;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        for (int c = 1; c <= 10 * BD + 1; c++) begin
            if (c == 1) check({tag, "_done_clr"}, tx_done, 1'b0);
            if ((c % BD) == BD / 2)
                check($sformatf("%s_bit%0d", tag, c / BD), TX, frame_bit(b, c / BD));
            if (c == 10 * BD) check({tag, "_done_early"}, tx_done, 1'b0);
            if (c == 10 * BD + 1) begin
                check({tag, "_done"}, tx_done, 1'b1);
                check({tag, "_idle"}, TX, 1'b1);
            end
            if (retrig && c == 5 * BD) begin
                resp = 8'h00;
                trmt = 1'b1;
            end else begin
                trmt = 1'b0;
            end
            if (c <= 10 * BD) @(negedge clk);
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cmd = 16'h0000;
        exp_rdy = 1'b0;
        check({tag, "_tx"}, TX, 1'b1);
        check({tag, "_cmd"}, cmd, exp_cmd);
        check({tag, "_rdy"}, cmd_rdy, exp_rdy);
        check({tag, "_done"}, tx_done, 1'b0);
    endtask

    initial begin
        int r0;
        logic [15:0] rc;
        logic [15:0] c1;
        logic [15:0] c2;

        RX = 1'b1;
        rst_n = 1'b0;
        trmt = 1'b0;
        resp = 8'h00;
        clr_cmd_rdy = 1'b0;
        exp_cmd = 16'h0000;
        exp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        do_reset("reset");
        repeat (5) @(negedge clk);

        // basic command, single rise, then consume
        r0 = rises;
        send_cmd(16'h2BF0, 1'b0, "c2BF0");
        check("c2BF0_rises", rises - r0, 1);
        repeat (4) @(negedge clk);
        clr_pulse("c2BF0");

        // unconsumed command overwritten by the next one
        send_cmd(16'h4000, 1'b0, "c4000");
        repeat (7) @(negedge clk);
        send_cmd(16'h2000, 1'b0, "c2000");

        // clear coinciding with completion: set wins
        send_cmd(16'h23F0, 1'b1, "c23F0");
        repeat (3) @(negedge clk);
        clr_pulse("c23F0");

        // transmit with an ignored mid-frame retrigger
        tx_frame(8'hA5, 1'b1, "txA5");
        repeat (5) @(negedge clk);

        // reset after first byte discards the partial high byte
        send_byte(8'h27, 1'b0);
        repeat (2) @(negedge clk);
        do_reset("rst_mid");
        send_cmd(16'h0000, 1'b0, "c0000");

        // reset in the middle of a transmit frame
        resp = 8'h3C;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (2 * BD + BD / 2) @(negedge clk);
        check("tx3C_mid", TX, frame_bit(8'h3C, 2));
        do_reset("rst_tx");
        repeat (3) @(negedge clk);

        // back-to-back commands with concurrent transmit
        c1 = 16'h1234;
        c2 = 16'hBEEF;
        fork
            begin
                send_cmd(c1, 1'b0, "b2b1");
                send_cmd(c2, 1'b0, "b2b2");
            end
            begin
                repeat (37) @(negedge clk);
                tx_frame(8'hA5, 1'b0, "dupA5");
            end
        join
        repeat (4) @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 8; i++) begin
            rc = 16'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_cmd(rc, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
                clr_pulse($sformatf("rnd%0d", i));
            end
        end
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            tx_frame(8'($urandom), 1'($urandom_range(0, 1)), $sformatf("rtx%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
